// File: rtl/alu_cmd_feeder.sv
// alu_cmd_feeder: 4-deep command FIFO feeding a registered 4-bit ALU.
// The FSM issues a command, waits out the ALU's output register, captures
// the result and holds it until the consumer accepts it.
// Optional result checker: define ALU_CMD_CHECK_EN to enable res_err.
module alu_cmd_feeder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_opcode,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [1:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_c,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_data,
  output logic [1:0] res_opcode,
  output logic [2:0] fifo_count,
  output logic       res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

  state_e     state_q, state_d;

  // FIFO entry layout: {opcode[9:8], a[7:4], b[3:0]}
  logic [9:0] mem_q [4];
  logic [9:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       push, pop;
  logic [9:0] head;

  logic [1:0] alu_opcode_q, alu_opcode_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       res_valid_q, res_valid_d;
  logic [4:0] res_data_q, res_data_d;
  logic [1:0] res_opcode_q, res_opcode_d;

  assign cmd_ready  = (count_q < 3'd4);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q];

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_opcode = res_opcode_q;
  assign fifo_count = count_q;

  // FSM next state, issue of the FIFO head and result capture/hold
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_opcode_d = res_opcode_q;
    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        res_data_d   = alu_c;
        res_opcode_d = alu_opcode_q;
        res_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      {alu_opcode_d, alu_a_d, alu_b_d} = head;
    end
  end

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_opcode, cmd_a, cmd_b};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  // State, FIFO and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_opcode_q <= res_opcode_d;
    end
  end

`ifdef ALU_CMD_CHECK_EN
  logic       res_err_q, res_err_d;
  logic [4:0] sa, sb, exp_c;

  // Expected ALU result from the issued command; sticky flag on mismatch in CAPT
  always_comb begin
    sa = {alu_a_q[3], alu_a_q};
    sb = {alu_b_q[3], alu_b_q};
    case (alu_opcode_q)
      2'b00:   exp_c = sa + sb;
      2'b01:   exp_c = sa - sb;
      2'b10:   exp_c = ~sa;
      default: exp_c = {4'b0000, |alu_b_q};
    endcase
    res_err_d = res_err_q | ((state_q == CAPT) && (alu_c != exp_c));
  end

  // Mismatch flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_err_q <= 1'b0;
    end else begin
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Self-checking bench for alu_cmd_feeder with a behavioural ALU and
// a queue-based reference model of the feeder.
module tb_alu_cmd_feeder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_opcode;
  logic [3:0] cmd_a, cmd_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_c;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_data;
  logic [1:0] res_opcode;
  logic [2:0] fifo_count;
  logic       res_err;
  logic       alu_rst;
  logic       force_zero;

  int n_chk = 0;
  int n_err = 0;

  alu_cmd_feeder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode),
    .fifo_count (fifo_count),
    .res_err    (res_err)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode on signed 4-bit operands, wrapped to 5 bits
  function automatic logic [4:0] calc(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    int sa, sb, r;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = -sa - 1;
      default: r = (b != 4'd0) ? 1 : 0;
    endcase
    return 5'(r);
  endfunction

  // Registered ALU with active-high reset tied to ~reset_n
  assign alu_rst = ~reset_n;
  always @(posedge clk or posedge alu_rst) begin
    if (alu_rst) alu_c <= '0;
    else         alu_c <= force_zero ? 5'd0 : calc(alu_opcode, alu_a, alu_b);
  end

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: pending queue, engine age since issue (-1 = free)
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t q[$];
  cmd_t cur;
  bit   cur_zero;
  int   age;
  bit   err_m;
  int   n_deliv;

  function automatic void model_reset();
    q.delete();
    cur      = '0;
    cur_zero = 1'b0;
    age      = -1;
    err_m    = 1'b0;
  endfunction

  function automatic logic [4:0] model_data();
    return cur_zero ? 5'd0 : calc(cur.op, cur.a, cur.b);
  endfunction

  function automatic void compare_all();
    chk("cmd_ready", int'(cmd_ready), (q.size() < 4) ? 1 : 0);
    chk("fifo_count", int'(fifo_count), q.size());
    chk("res_valid", int'(res_valid), (age >= 2) ? 1 : 0);
    chk("alu_opcode", int'(alu_opcode), int'(cur.op));
    chk("alu_a", int'(alu_a), int'(cur.a));
    chk("alu_b", int'(alu_b), int'(cur.b));
    chk("res_err", int'(res_err), int'(err_m));
    if (age >= 2) begin
      chk("res_data", int'(res_data), int'(model_data()));
      chk("res_opcode", int'(res_opcode), int'(cur.op));
    end
  endfunction

  // Advance the model by one clock using the inputs now applied, then compare
  task automatic step();
    bit hs, free, do_pop, do_push;
    if (reset_n) begin
      hs      = (age >= 2) && res_ready;
      free    = (age < 0) || hs;
      do_pop  = free && (q.size() > 0);
      do_push = cmd_valid && (q.size() < 4);
      if (hs) n_deliv++;
      if (do_pop) begin
        cur      = q.pop_front();
        cur_zero = force_zero;
        age      = 0;
      end else if (hs) begin
        age = -1;
      end else if (age >= 0 && age < 2) begin
        age++;
`ifdef ALU_CMD_CHECK_EN
        if (age == 2 && model_data() != calc(cur.op, cur.a, cur.b)) err_m = 1'b1;
`endif
      end
      if (do_push) q.push_back('{cmd_opcode, cmd_a, cmd_b});
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"add_7_7",     2'd0, 4'd7,  4'd7,  5'b01110};
    vecs[1] = '{"sub_m8_7",    2'd1, 4'h8,  4'd7,  5'b10001};
    vecs[2] = '{"not_5",       2'd2, 4'd5,  4'd0,  5'b11010};
    vecs[3] = '{"or_b0",       2'd3, 4'hF,  4'd0,  5'b00000};
    vecs[4] = '{"or_b8",       2'd3, 4'd0,  4'h8,  5'b00001};
    vecs[5] = '{"add_m8_m8",   2'd0, 4'h8,  4'h8,  5'b10000};
    vecs[6] = '{"sub_7_m8",    2'd1, 4'd7,  4'h8,  5'b01111};
    vecs[7] = '{"not_m8",      2'd2, 4'h8,  4'h3,  5'b00111};

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    res_ready  = 1'b0;
    force_zero = 1'b0;
    n_deliv    = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Single commands: push, issue, 3-cycle result latency, hold, accept
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_opcode = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
      step();
      cmd_valid = 1'b0;
      chk({vecs[i].nm, "_count1"}, int'(fifo_count), 1);
      step();
      chk({vecs[i].nm, "_issue_a"}, int'(alu_a), int'(vecs[i].a));
      step();
      chk({vecs[i].nm, "_early_valid"}, int'(res_valid), 0);
      step();
      chk({vecs[i].nm, "_valid"}, int'(res_valid), 1);
      chk({vecs[i].nm, "_data"}, int'(res_data), int'(vecs[i].exp));
      chk({vecs[i].nm, "_opcode"}, int'(res_opcode), int'(vecs[i].op));
      step();
      chk({vecs[i].nm, "_hold"}, int'(res_data), int'(vecs[i].exp));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({vecs[i].nm, "_cleared"}, int'(res_valid), 0);
    end

    // Engine occupied, then 5 back-to-back pushes: only 4 fit
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_a = 4'd1; cmd_b = 4'd2;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 2'(i);
      cmd_a      = 4'(i + 3);
      cmd_b      = 4'(9 - i);
      step();
    end
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(cmd_ready), 0);
    step();
    cmd_valid = 1'b0;
    chk("full_held", int'(fifo_count), 4);
    n_deliv   = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 30 && n_deliv < 5; i++) step();
    chk("drain_delivered", n_deliv, 5);
    step();
    chk("drain_count", int'(fifo_count), 0);
    res_ready = 1'b0;
    repeat (2) step();

    // Reset while in CAPT with two queued commands
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_a = 4'd2; cmd_b = 4'd3;
    step();
    cmd_opcode = 2'd1; cmd_a = 4'd4;
    step();
    cmd_opcode = 2'd2; cmd_a = 4'd6;
    step();
    cmd_valid = 1'b0;
    chk("capt_count", int'(fifo_count), 2);
    chk("capt_valid", int'(res_valid), 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) step();
    reset_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("post_reset_count", int'(fifo_count), 0);
    res_ready = 1'b0;

    // Wrong ALU result for add 3+2
    force_zero = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_a = 4'd3; cmd_b = 4'd2;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("forced_data", int'(res_data), 0);
`ifdef ALU_CMD_CHECK_EN
    chk("err_set", int'(res_err), 1);
`else
    chk("err_tied", int'(res_err), 0);
`endif
    force_zero = 1'b0;
    res_ready  = 1'b1;
    step();
    res_ready  = 1'b0;
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_a = 4'd1; cmd_b = 4'd1;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
`ifdef ALU_CMD_CHECK_EN
    chk("err_sticky", int'(res_err), 1);
`endif
    res_ready = 1'b1;
    step();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("err_reset", int'(res_err), 0);
    step();
    reset_n = 1'b1;
    step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cmd_valid  = ($urandom_range(0, 99) < 60);
      cmd_opcode = 2'($urandom);
      cmd_a      = 4'($urandom);
      cmd_b      = 4'($urandom);
      res_ready  = ($urandom_range(0, 99) < 35);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("final_count", int'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
